alu_seq: RTL



---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_mul_iter.sv | 50 +++++
 rtl/alu_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and NZCV flag layout for alu_seq.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps.
// done_o is high during the final step; product_o then carries the complete product.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     acc;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    acc    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {acc, prod_q[WIDTH-1:1]};
  end

  assign done_o    = busy_q && (cnt_q == CntW'(1));
  assign product_o = prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      mcand_q <= a_i;
      prod_q  <= {{WIDTH{1'b0}}, b_i};
      cnt_q   <= CntW'(WIDTH);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      prod_q <= prod_d;
      cnt_q  <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered Result/NZCV flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for opcode 111.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, shl, shr;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;
  logic             is_mul;

  always_comb begin
    shamt   = b[SHW-1:0];
    sum     = {1'b0, a} + {1'b0, (ALUControl[0] ? ~b : b)} + {{WIDTH{1'b0}}, ALUControl[0]};
    // Extra bit on each side catches the last bit shifted out.
    shl     = {1'b0, a} << shamt;
    shr     = {a, 1'b0} >> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ ALUControl[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_LSL: begin
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OP_LSR: begin
        alu_res = shr[WIDTH:1];
        alu_c   = shr[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags = pack_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);
    is_mul    = MulEn && (ALUControl == OP_MUL);
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0]         mul_flags;

  assign mul_start = (state_q == S_IDLE) && in_valid && is_mul;
  assign mul_flags = pack_flags(mul_prod[WIDTH-1], mul_prod[WIDTH-1:0] == '0,
                                |mul_prod[2*WIDTH-1:WIDTH], 1'b0);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .a_i      (a),
    .b_i      (b),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              state_q <= S_BUSY;
            end else begin
              result_q    <= alu_res;
              flags_q     <= alu_flags;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_BUSY: begin
          if (mul_done) begin
            result_q    <= mul_prod[WIDTH-1:0];
            flags_q     <= mul_flags;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign ALUFlags  = flags_q;

endmodule
